// File: rtl/rom_download_packer_if.sv
// ---------------------------------------------------------------------------
// rom_download_packer_if
// Purpose : bundles the HPS ioctl download port and the memory-side word
//           write handshake used by rom_download_packer.
// Signals :
//   ioctl_download  download window active (HPS -> packer)
//   ioctl_wr        one-cycle byte strobe (HPS -> packer)
//   ioctl_addr      25-bit byte address (HPS -> packer)
//   ioctl_dout      byte data (HPS -> packer)
//   ioctl_wait      stall request (packer -> HPS)
//   sdr_req         word write request (packer -> memory)
//   sdr_addr        word address of FIFO head (packer -> memory)
//   sdr_data        {high byte, low byte} of FIFO head (packer -> memory)
//   sdr_ack         one-cycle accept of the head (memory -> packer)
// Modports: slave = the packer itself, master = the environment driving it.
// ---------------------------------------------------------------------------
interface rom_download_packer_if #(
  parameter int AW = 22
) ();
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic          sdr_req;
  logic [AW-1:0] sdr_addr;
  logic [15:0]   sdr_data;
  logic          sdr_ack;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
    output ioctl_wait, sdr_req, sdr_addr, sdr_data
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
    input  ioctl_wait, sdr_req, sdr_addr, sdr_data
  );
endinterface

// File: rtl/rom_download_packer.sv
// ---------------------------------------------------------------------------
// rom_download_packer
// Purpose : packs the byte-wide ROM download stream into 16-bit little-endian
//           words, queues them in a small FIFO, writes them to memory over a
//           req/ack handshake, throttles HPS, flags end of load and checks the
//           four-byte ROM signature.
// Ports   :
//   i_clk_sys     system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   bus           rom_download_packer_if.slave (ioctl and sdr signals)
//   o_busy        download or flush in progress
//   o_done        one-cycle pulse when all words of a load are written
//   o_sig_match   bytes 0..3 of the load equal SIG
//   o_overflow    sticky, a word was dropped on a full FIFO
//   o_word_count  words accepted by memory in this load (saturating)
// ---------------------------------------------------------------------------
module rom_download_packer #(
  parameter int          AW         = 22,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  PAD_BYTE   = 8'hFF,
  parameter logic [31:0] SIG        = 32'h10830080
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst_n,
  rom_download_packer_if.slave bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_sig_match,
  output logic                 o_overflow,
  output logic [AW:0]          o_word_count
);

  localparam int             PW       = $clog2(FIFO_DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  WAIT_LVL = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t        r_state;
  logic          r_dl_d;
  logic          r_busy, r_done, r_sig_match, r_overflow, r_wait;
  logic [3:0]    r_sig_flag;
  logic [AW:0]   r_word_count;
  logic [AW-1:0] r_pw_addr;
  logic [15:0]   r_pw_data;
  logic [1:0]    r_pw_mask;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW-1:0] r_mem_addr [FIFO_DEPTH];
  logic [15:0]   r_mem_data [FIFO_DEPTH];

  logic          w_start, w_end, w_wr, w_lane;
  logic [AW-1:0] w_waddr;
  logic [15:0]   w_pad_data, w_merge_data;
  logic [1:0]    w_merge_mask;
  logic          w_push, w_pop, w_accept, w_drop;
  logic [AW-1:0] w_push_addr, w_pw_addr_next;
  logic [15:0]   w_push_data, w_pw_data_next;
  logic [1:0]    w_pw_mask_next;
  logic [CW-1:0] w_count_next;
  logic [7:0]    w_sig_byte;

  assign w_waddr = bus.ioctl_addr[AW:1];
  assign w_lane  = bus.ioctl_addr[0];
  assign w_start = bus.ioctl_download & ~r_dl_d & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_end   = ~bus.ioctl_download & r_dl_d & (r_state == S_LOAD);
  // The end-of-download cycle already has ioctl_download low, so a strobe
  // there is outside the window and is dropped.
  assign w_wr    = bus.ioctl_wr & (r_state == S_LOAD) & ~w_end;

  // Pending word with never-written lanes filled with the pad byte.
  assign w_pad_data = {r_pw_mask[1] ? r_pw_data[15:8] : PAD_BYTE,
                       r_pw_mask[0] ? r_pw_data[7:0]  : PAD_BYTE};

  always_comb begin
    w_merge_data = r_pw_data;
    if (w_lane) w_merge_data[15:8] = bus.ioctl_dout;
    else        w_merge_data[7:0]  = bus.ioctl_dout;
    w_merge_mask = r_pw_mask | (w_lane ? 2'b10 : 2'b01);
  end

  // Pending-word update and the (single) push decision for this cycle.
  always_comb begin
    w_push         = 1'b0;
    w_push_addr    = r_pw_addr;
    w_push_data    = w_pad_data;
    w_pw_addr_next = r_pw_addr;
    w_pw_data_next = r_pw_data;
    w_pw_mask_next = r_pw_mask;
    if (w_start) begin
      w_pw_mask_next = 2'b00;
    end else if (w_end) begin
      w_push         = (r_pw_mask != 2'b00);
      w_pw_mask_next = 2'b00;
    end else if (w_wr) begin
      if ((r_pw_mask != 2'b00) && (w_waddr != r_pw_addr)) begin
        // Address moved on: retire the partial word, start a fresh one.
        w_push         = 1'b1;
        w_pw_addr_next = w_waddr;
        w_pw_data_next = w_lane ? {bus.ioctl_dout, PAD_BYTE} : {PAD_BYTE, bus.ioctl_dout};
        w_pw_mask_next = w_lane ? 2'b10 : 2'b01;
      end else begin
        w_pw_addr_next = w_waddr;
        w_pw_data_next = w_merge_data;
        if (w_merge_mask == 2'b11) begin
          w_push         = 1'b1;
          w_push_addr    = w_waddr;
          w_push_data    = w_merge_data;
          w_pw_mask_next = 2'b00;
        end else begin
          w_pw_mask_next = w_merge_mask;
        end
      end
    end
  end

  assign w_pop    = bus.sdr_ack & (r_count != '0);
  assign w_accept = w_push & ((r_count != FULL_LVL) | w_pop);
  assign w_drop   = w_push & ~w_accept;

  always_comb begin
    w_count_next = r_count;
    if (w_accept & ~w_pop)      w_count_next = r_count + CNT_ONE;
    else if (~w_accept & w_pop) w_count_next = r_count - CNT_ONE;
  end

  always_comb begin
    case (bus.ioctl_addr[1:0])
      2'd0:    w_sig_byte = SIG[31:24];
      2'd1:    w_sig_byte = SIG[23:16];
      2'd2:    w_sig_byte = SIG[15:8];
      default: w_sig_byte = SIG[7:0];
    endcase
  end

  // FIFO storage carries no reset; only the count/pointers define validity.
  always_ff @(posedge i_clk_sys) begin
    if (w_accept) begin
      r_mem_addr[r_wr_ptr] <= w_push_addr;
      r_mem_data[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_dl_d       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sig_match  <= 1'b0;
      r_overflow   <= 1'b0;
      r_wait       <= 1'b0;
      r_sig_flag   <= 4'b0000;
      r_word_count <= '0;
      r_pw_addr    <= '0;
      r_pw_data    <= '0;
      r_pw_mask    <= 2'b00;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_dl_d    <= bus.ioctl_download;
      r_done    <= 1'b0;
      r_pw_addr <= w_pw_addr_next;
      r_pw_data <= w_pw_data_next;
      r_pw_mask <= w_pw_mask_next;
      r_count   <= w_count_next;
      r_wait    <= (w_count_next >= WAIT_LVL);
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_drop)   r_overflow <= 1'b1;
      if (w_pop && !(&r_word_count)) r_word_count <= r_word_count + 1'b1;
      if (w_wr && (bus.ioctl_addr[24:2] == '0))
        r_sig_flag[bus.ioctl_addr[1:0]] <= (bus.ioctl_dout == w_sig_byte);
      r_sig_match <= &r_sig_flag;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state      <= S_LOAD;
            r_busy       <= 1'b1;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_sig_flag   <= 4'b0000;
            r_sig_match  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_end) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_count == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sdr_req    = (r_count != '0);
  // Outputs read as zero when nothing is queued, including right after reset.
  assign bus.sdr_addr   = bus.sdr_req ? r_mem_addr[r_rd_ptr] : '0;
  assign bus.sdr_data   = bus.sdr_req ? r_mem_data[r_rd_ptr] : '0;
  assign bus.ioctl_wait = r_wait;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_sig_match    = r_sig_match;
  assign o_overflow     = r_overflow;
  assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_rom_download_packer.sv
// ---------------------------------------------------------------------------
// tb_rom_download_packer
// Purpose : directed self-checking bench for rom_download_packer. A monitor
//           process acks each request one cycle after it appears (when
//           enabled), logs accepted words and counts done pulses.
// ---------------------------------------------------------------------------
module tb_rom_download_packer;
  localparam int AW = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, done, sig_match, overflow;
  logic [AW:0] word_count;

  rom_download_packer_if #(.AW(AW)) bus ();

  rom_download_packer #(.AW(AW)) dut (
    .i_clk_sys    (clk),
    .i_rst_n      (rst_n),
    .bus          (bus.slave),
    .o_busy       (busy),
    .o_done       (done),
    .o_sig_match  (sig_match),
    .o_overflow   (overflow),
    .o_word_count (word_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  bit          auto_ack = 1'b0;
  int          done_cnt = 0;
  logic [31:0] got_addr [$];
  logic [31:0] got_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Ack monitor: decisions are made 1 time unit after each rising edge.
  initial begin
    bus.sdr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (auto_ack && bus.sdr_req && !bus.sdr_ack) begin
        got_addr.push_back(32'(bus.sdr_addr));
        got_data.push_back(32'(bus.sdr_data));
        bus.sdr_ack = 1'b1;
      end else begin
        bus.sdr_ack = 1'b0;
      end
    end
  end

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = a; bus.ioctl_dout = d;
    @(posedge clk); #2;
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    @(posedge clk); #2;
    bus.ioctl_download = 1'b1;
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    @(posedge clk); #2;
  endtask

  // Ends the download and waits (bounded) for the done pulse.
  task automatic end_dl(input string tag);
    int n = 0;
    @(posedge clk); #2;
    bus.ioctl_download = 1'b0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (4) @(posedge clk);
    #2;
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < got_addr.size()) begin
      check($sformatf("%s_w%0d_addr", tag, idx), got_addr[idx], a);
      check($sformatf("%s_w%0d_data", tag, idx), got_data[idx], d);
    end else begin
      check($sformatf("%s_w%0d_present", tag, idx), 32'(got_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req", 32'(bus.sdr_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wait", 32'(bus.ioctl_wait), 0);
    check("rst_wcnt", 32'(word_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_sig", 32'(sig_match), 0);
    rst_n = 1'b1;

    // Sequential bytes with signature.
    auto_ack = 1'b1;
    start_dl();
    check("t1_busy", 32'(busy), 1);
    wr_byte(0, 8'h10); wr_byte(1, 8'h83); wr_byte(2, 8'h00);
    wr_byte(3, 8'h80); wr_byte(4, 8'hAA); wr_byte(5, 8'hBB);
    end_dl("t1");
    check("t1_nwords", 32'(got_addr.size()), 3);
    check_word("t1", 0, 0, 32'h8310);
    check_word("t1", 1, 1, 32'h8000);
    check_word("t1", 2, 2, 32'hBBAA);
    check("t1_sig", 32'(sig_match), 1);
    check("t1_wcnt", 32'(word_count), 3);

    // Single high-lane byte, padded at end.
    start_dl();
    wr_byte(7, 8'h55);
    end_dl("t2");
    check("t2_nwords", 32'(got_addr.size()), 1);
    check_word("t2", 0, 3, 32'h55FF);
    check("t2_wcnt", 32'(word_count), 1);

    // Address gap retires the partial word.
    start_dl();
    wr_byte(0, 8'h10);
    wr_byte(4, 8'h3C);
    repeat (3) @(posedge clk);
    #2;
    check("t3_gap_nwords", 32'(got_addr.size()), 1);
    end_dl("t3");
    check_word("t3", 0, 0, 32'hFF10);
    check_word("t3", 1, 2, 32'hFF3C);
    check("t3_sig", 32'(sig_match), 0);

    // Back-pressure and overflow.
    auto_ack = 1'b0;
    start_dl();
    for (int i = 0; i < 10; i++) begin
      wr_byte(25'(i), 8'(8'h20 + i));
      if (i == 3) check("t4_wait_at2", 32'(bus.ioctl_wait), 0);
      if (i == 5) check("t4_wait_at3", 32'(bus.ioctl_wait), 1);
      if (i == 7) check("t4_ovf_at4", 32'(overflow), 0);
    end
    check("t4_ovf", 32'(overflow), 1);
    check("t4_req", 32'(bus.sdr_req), 1);
    auto_ack = 1'b1;
    end_dl("t4");
    check("t4_nwords", 32'(got_addr.size()), 4);
    check_word("t4", 0, 0, 32'h2120);
    check_word("t4", 1, 1, 32'h2322);
    check_word("t4", 2, 2, 32'h2524);
    check_word("t4", 3, 3, 32'h2726);
    check("t4_wcnt", 32'(word_count), 4);
    check("t4_wait_end", 32'(bus.ioctl_wait), 0);

    // Bad then good signature.
    start_dl();
    check("t5a_ovf_clr", 32'(overflow), 0);
    wr_byte(0, 8'h10); wr_byte(1, 8'h83); wr_byte(2, 8'h01); wr_byte(3, 8'h80);
    end_dl("t5a");
    check("t5a_sig", 32'(sig_match), 0);
    start_dl();
    wr_byte(0, 8'h10); wr_byte(1, 8'h83); wr_byte(2, 8'h00); wr_byte(3, 8'h80);
    end_dl("t5b");
    check("t5b_sig", 32'(sig_match), 1);
    check("t5b_ovf", 32'(overflow), 0);

    // Reset in the middle of a load.
    auto_ack = 1'b0;
    start_dl();
    wr_byte(0, 8'h01); wr_byte(1, 8'h02); wr_byte(2, 8'h03); wr_byte(3, 8'h04);
    check("t6_req_before", 32'(bus.sdr_req), 1);
    rst_n = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    check("t6_req", 32'(bus.sdr_req), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_wcnt", 32'(word_count), 0);
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("t6_no_done", 32'(done_cnt), 0);
    auto_ack = 1'b1;
    start_dl();
    wr_byte(2, 8'h77); wr_byte(3, 8'h66);
    end_dl("t6r");
    check("t6r_nwords", 32'(got_addr.size()), 1);
    check_word("t6r", 0, 1, 32'h6677);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
